// File: rtl/tick_generator.sv
// Programmable tick generator: divisor-paced one-cycle ticks, finite or continuous bursts.
// Optional half-period phase output enabled by defining TICK_GENERATOR_PHASE_EN.
module tick_generator #(
   parameter int unsigned     WIDTH     = 16,
   parameter int unsigned     CNT_WIDTH = 16,
   parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 start,
   input  logic                 stop,
   input  logic [CNT_WIDTH-1:0] burst_len,
   input  logic [WIDTH-1:0]     divisor,
   input  logic                 divisor_wr,
   output logic                 tick,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] remaining
`ifdef TICK_GENERATOR_PHASE_EN
   ,
   output logic                 tick_half
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_count;
   logic [WIDTH-1:0]     w_count_nxt;
   logic [WIDTH-1:0]     r_div;
   logic [WIDTH-1:0]     w_div_nxt;
   logic [WIDTH-1:0]     r_pend;
   logic [WIDTH-1:0]     w_pend_nxt;
   logic                 r_pend_vld;
   logic                 w_pend_vld_nxt;
   logic [CNT_WIDTH-1:0] r_rem;
   logic [CNT_WIDTH-1:0] w_rem_nxt;
   logic                 r_tick;
   logic                 w_tick_nxt;
   logic                 r_busy;
   logic                 r_done;
   logic                 w_done_nxt;
   logic                 w_run_en;
   logic                 w_wrap;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_count    <= '0;
         r_div      <= RESET_DIV;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_rem      <= '0;
         r_tick     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_div      <= w_div_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_rem      <= w_rem_nxt;
         r_tick     <= w_tick_nxt;
         r_busy     <= (w_state_nxt == ST_RUN);
         r_done     <= w_done_nxt;
      end
   end

   // Next-state, counter, burst and divisor update logic
   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_rem_nxt      = r_rem;
      w_tick_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
      w_div_nxt      = r_div;
      w_pend_nxt     = r_pend;
      w_pend_vld_nxt = r_pend_vld;
      w_run_en       = (r_state == ST_RUN) && enable;
      w_wrap         = w_run_en && (r_count == r_div);

      case (r_state)
         ST_IDLE: begin
            w_count_nxt = '0;
            if (start && !stop) begin
               w_state_nxt = ST_RUN;
               w_rem_nxt   = burst_len;
            end
         end
         ST_RUN: begin
            if (stop) begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
               w_rem_nxt   = '0;
            end else if (enable) begin
               if (w_wrap) begin
                  w_count_nxt = '0;
                  w_tick_nxt  = 1'b1;
                  // remaining == 0 marks continuous mode and never counts
                  if (r_rem != '0) begin
                     w_rem_nxt = r_rem - CNT_WIDTH'(1);
                     if (r_rem == CNT_WIDTH'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                     end
                  end
               end else begin
                  w_count_nxt = r_count + WIDTH'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
         end
      endcase

      // Pending divisor only lands on a period boundary; a coinciding write waits for the next one
      if (r_pend_vld && ((r_state == ST_IDLE) || w_wrap)) begin
         w_div_nxt      = r_pend;
         w_pend_vld_nxt = 1'b0;
      end
      if (divisor_wr) begin
         w_pend_nxt     = divisor;
         w_pend_vld_nxt = 1'b1;
      end
   end

   assign tick      = r_tick;
   assign busy      = r_busy;
   assign done      = r_done;
   assign remaining = r_rem;

`ifdef TICK_GENERATOR_PHASE_EN
   logic r_tick_half;
   logic w_half_nxt;

   assign w_half_nxt = w_run_en && !stop && (r_count == (r_div >> 1));

   // Mid-period phase pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_half <= 1'b0;
      end else begin
         r_tick_half <= w_half_nxt;
      end
   end

   assign tick_half = r_tick_half;
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Scoreboard bench for tick_generator: expected outputs are queued as stimulus is driven
// and popped against the DUT one cycle later.
module tb_tick_generator;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned CNT_WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable;
   logic                 start;
   logic                 stop;
   logic [CNT_WIDTH-1:0] burst_len;
   logic [WIDTH-1:0]     divisor;
   logic                 divisor_wr;
   logic                 tick;
   logic                 busy;
   logic                 done;
   logic [CNT_WIDTH-1:0] remaining;
`ifdef TICK_GENERATOR_PHASE_EN
   logic                 tick_half;
`endif

   typedef struct packed {
      logic                 tick;
      logic                 busy;
      logic                 done;
      logic [CNT_WIDTH-1:0] rem;
      logic                 half_vld;
      logic                 half;
   } exp_t;

   exp_t  sb_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   string tag   = "reset";

   always #5 clk = ~clk;

   tick_generator #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .RESET_DIV ('0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .start      (start),
      .stop       (stop),
      .burst_len  (burst_len),
      .divisor    (divisor),
      .divisor_wr (divisor_wr),
      .tick       (tick),
      .busy       (busy),
      .done       (done),
      .remaining  (remaining)
`ifdef TICK_GENERATOR_PHASE_EN
      ,
      .tick_half  (tick_half)
`endif
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
      end
   endtask

   // Queue the outputs expected after the next edge, then compare once the DUT has produced them
   task automatic step(input logic t, input logic b, input logic d, input int r,
                       input logic hv = 1'b0, input logic h = 1'b0);
      exp_t e;
      e.tick     = t;
      e.busy     = b;
      e.done     = d;
      e.rem      = CNT_WIDTH'(r);
      e.half_vld = hv;
      e.half     = h;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "/sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check({tag, "/tick"},      32'(tick),      32'(e.tick));
         check({tag, "/busy"},      32'(busy),      32'(e.busy));
         check({tag, "/done"},      32'(done),      32'(e.done));
         check({tag, "/remaining"}, 32'(remaining), 32'(e.rem));
`ifdef TICK_GENERATOR_PHASE_EN
         if (e.half_vld) check({tag, "/tick_half"}, 32'(tick_half), 32'(e.half));
`endif
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
   endtask

   // Load a divisor while idle: captured on the first edge, active after the second
   task automatic set_div(input int d);
      divisor    = WIDTH'(d);
      divisor_wr = 1'b1;
      step(1'b0, 1'b0, 1'b0, 0);
      divisor_wr = 1'b0;
      step(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic start_run(input int blen);
      start     = 1'b1;
      burst_len = CNT_WIDTH'(blen);
      step(1'b0, 1'b1, 1'b0, blen);
      start     = 1'b0;
   endtask

   task automatic stop_run();
      stop = 1'b1;
      step(1'b0, 1'b0, 1'b0, 0);
      stop = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      enable     = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      burst_len  = '0;
      divisor    = '0;
      divisor_wr = 1'b0;

      tag = "reset";
      step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      rst = 1'b0;
      idle(2);

      // D=3, four-tick burst; a second start mid-run must be ignored
      tag = "burst_d3";
      set_div(3);
      start_run(4);
      for (int k = 1; k <= 16; k++) begin
         start     = (k == 2);
         burst_len = (k == 2) ? CNT_WIDTH'(9) : CNT_WIDTH'(4);
         step((k % 4) == 0, k < 16, k == 16, 4 - k / 4);
      end
      start = 1'b0;
      idle(3);

      tag = "start_stop_idle";
      start = 1'b1;
      stop  = 1'b1;
      step(1'b0, 1'b0, 1'b0, 0);
      start = 1'b0;
      stop  = 1'b0;
      idle(2);

      // D=0 continuous: tick every cycle until stop
      tag = "cont_d0";
      set_div(0);
      start_run(0);
      for (int k = 1; k <= 10; k++) step(1'b1, 1'b1, 1'b0, 0);
      stop_run();
      idle(3);

      // D=5, rewrite to 2 mid-period: one 6-cycle period completes, then 3-cycle periods
      tag = "div_change";
      set_div(5);
      start_run(0);
      divisor = WIDTH'(2);
      for (int k = 1; k <= 21; k++) begin
         divisor_wr = (k == 8);
         step((k <= 12) ? ((k % 6) == 0) : (((k - 12) % 3) == 0), 1'b1, 1'b0, 0);
      end
      divisor_wr = 1'b0;
      stop_run();
      idle(1);

      // D=4, enable low for 7 edges mid-period: second tick slips from 10 to 17
      tag = "pause";
      set_div(4);
      start_run(0);
      for (int k = 1; k <= 22; k++) begin
         enable = !(k >= 7 && k <= 13);
         step((k == 5) || (k == 17) || (k == 22), 1'b1, 1'b0, 0);
      end
      enable = 1'b1;
      stop_run();
      idle(1);

      // D=3, write coinciding with the wrap at 4 takes effect at the wrap at 8
      tag = "wr_at_wrap";
      set_div(3);
      start_run(0);
      divisor = WIDTH'(1);
      for (int k = 1; k <= 12; k++) begin
         divisor_wr = (k == 4);
         step((k == 4) || (k == 8) || (k == 10) || (k == 12), 1'b1, 1'b0, 0);
      end
      divisor_wr = 1'b0;
      stop_run();
      idle(1);

      // D=2, burst 2; reset one cycle before the terminal tick with a divisor pending
      tag = "rst_mid_run";
      set_div(2);
      start_run(2);
      step(1'b0, 1'b1, 1'b0, 2);
      step(1'b0, 1'b1, 1'b0, 2);
      step(1'b1, 1'b1, 1'b0, 1);
      divisor    = WIDTH'(9);
      divisor_wr = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1);
      divisor_wr = 1'b0;
      rst        = 1'b1;
      step(1'b0, 1'b0, 1'b0, 0);
      rst        = 1'b0;
      idle(3);
      // Active divisor back at RESET_DIV=0 and the pending 9 gone: one-tick burst ends next cycle
      tag = "post_rst_div";
      start_run(1);
      step(1'b1, 1'b0, 1'b1, 0);
      idle(2);

`ifdef TICK_GENERATOR_PHASE_EN
      // D=7: tick_half leads each tick by 4 cycles
      tag = "phase_d7";
      set_div(7);
      start_run(0);
      for (int k = 1; k <= 24; k++)
         step((k % 8) == 0, 1'b1, 1'b0, 0, 1'b1, (k % 8) == 4);
      stop_run();
      idle(1);

      tag = "phase_d0";
      set_div(0);
      start_run(0);
      for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
      stop_run();
      idle(1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tick_generator.md
TICK_GENERATOR -- requirements
Module: tick_generator

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 16: divisor width in bits.
- REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: burst length width in bits.
- REQ-003 The block SHALL have parameter RESET_DIV, default 0: active divisor value after reset.
- REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic is on the posedge.
- REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006 The block SHALL have port enable, input, 1 bit: level; low pauses counting in RUN.
- REQ-007 The block SHALL have port start, input, 1 bit: pulse; begins a run from IDLE.
- REQ-008 The block SHALL have port stop, input, 1 bit: pulse; aborts a run.
- REQ-009 The block SHALL have port burst_len, input, CNT_WIDTH bits: tick count per run; 0 means continuous.
- REQ-010 The block SHALL have port divisor, input, WIDTH bits: new divisor value.
- REQ-011 The block SHALL have port divisor_wr, input, 1 bit: pulse; captures divisor into the pending register.
- REQ-012 The block SHALL have port tick, output, 1 bit: registered one-cycle pulse.
- REQ-013 The block SHALL have port busy, output, 1 bit: high while in RUN.
- REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a finite burst completes.
- REQ-015 The block SHALL have port remaining, output, CNT_WIDTH bits: ticks left in the current finite burst.

Function
- REQ-016 The block SHALL have two states: IDLE and RUN. Reset SHALL enter IDLE.
- REQ-017 IDLE, start=1, stop=0: go to RUN, clear counter to 0, load remaining with burst_len.
- REQ-018 RUN, enable=1: if counter != active divisor D, counter +1; else counter to 0 and tick=1 on the next cycle.
- REQ-019 Tick period SHALL be D+1 cycles. First tick SHALL be high D+1 cycles after the start edge. D=0 SHALL give a tick every cycle.
- REQ-020 RUN, enable=0: counter and remaining SHALL hold, and tick SHALL be 0 (pause, not reset).
- REQ-021 Finite burst (burst_len != 0): each tick decrements remaining. The tick that takes remaining from 1 to 0 SHALL assert done in the same cycle as that tick, and the block SHALL enter IDLE with busy=0 from that cycle.
- REQ-022 Continuous mode (burst_len=0 at start): remaining SHALL stay 0, done SHALL never assert, and the run SHALL continue until stop.
- REQ-023 stop in RUN: next cycle in IDLE, counter=0, remaining=0, tick=0, done=0. stop SHALL have priority over a coinciding terminal count.
- REQ-024 start while in RUN SHALL be ignored. start and stop together in IDLE: SHALL remain in IDLE.
- REQ-025 divisor_wr SHALL capture divisor into the pending register and set a pending flag. A later divisor_wr before application SHALL overwrite the pending value.
- REQ-026 In IDLE, a pending divisor SHALL become active on the next cycle.
- REQ-027 In RUN, a pending divisor SHALL become active only on a wrap (counter==D with enable=1), so no period is ever truncated or stretched.
- REQ-028 divisor_wr coinciding with a wrap SHALL apply at the next wrap, not the current one.
- REQ-029 Counter width SHALL be WIDTH and remaining width SHALL be CNT_WIDTH. D = 2^WIDTH-1 SHALL wrap cleanly with no overflow.

Reset
- REQ-030 rst SHALL force: state=IDLE, counter=0, active divisor=RESET_DIV, pending flag=0, remaining=0, tick=0, busy=0, done=0, tick_half=0.
- REQ-031 rst mid-run SHALL abort the run with no done pulse and SHALL discard any pending divisor. rst SHALL have priority over all other inputs.

Configuration
- REQ-032 With TICK_GENERATOR_PHASE_EN defined, the block SHALL have an output tick_half, 1 bit, registered. It SHALL pulse one cycle after counter == (D>>1) in RUN with enable=1. For D=0 it SHALL coincide with tick.
- REQ-033 Without TICK_GENERATOR_PHASE_EN, tick_half and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-034 Bench SHALL cover: D=3, burst_len=4, start -> ticks at cycles 4, 8, 12, 16 after start; done with the 4th tick; busy low afterwards; remaining 4->0.
- REQ-035 Bench SHALL cover: D=0, burst_len=0, start, stop after 10 cycles -> tick high every cycle until stop, done never asserts.
- REQ-036 Bench SHALL cover: D=5 running, divisor_wr with 2 mid-period -> current period stays 6 cycles, all following periods are 3 cycles.
- REQ-037 Bench SHALL cover: D=4, enable low for 7 cycles mid-period -> tick delayed by exactly 7 cycles, counter preserved.
- REQ-038 Bench SHALL cover: rst asserted one cycle before the terminal tick of a burst_len=2 run -> no tick, no done, all outputs 0, active divisor=RESET_DIV.
- REQ-039 Bench SHALL cover: with TICK_GENERATOR_PHASE_EN, D=7 -> tick_half 4 cycles before each tick.
